// File: rtl/dispatch_pkg.sv
// dispatch_pkg: widths and error-flag bit positions shared by
// the tagged dispatch FIFO bank and its per-channel FIFOs.
package dispatch_pkg;

    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;
    localparam int ERR_BAD_TAG   = 2;
    localparam int NUM_ERR       = 3;

    // Tag width; a single bit is kept even for a degenerate bank.
    function automatic int tag_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Address bits plus one wrap bit.
    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dispatch_channel_fifo.sv
// dispatch_channel_fifo: one first-word-fall-through circular FIFO.
// Ports: clk, rst (sync, active high), push/data_in write side,
// pop read strobe, data_out head word (0 when empty), full, empty.
module dispatch_channel_fifo
    import dispatch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (rptr == wptr);
    // Same slot, different lap: writer is a full lap ahead.
    assign full  = (rptr[AW-1:0] == wptr[AW-1:0]) &&
                   (rptr[AW] != wptr[AW]);

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wptr[AW-1:0]] <= data_in;
    end

    assign data_out = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/tagged_dispatch_fifos.sv
// tagged_dispatch_fifos: demultiplexes one tagged write stream into
// NUM_FIFOS independent FIFOs, optionally redirecting round-robin.
// Ports: clk, rst (sync, active high); push, tag_in, data_in,
// ready, acc_tag (write side); pop, flat_data_out, full, empty
// (per channel); err_overflow, err_underflow, err_bad_tag (sticky).
module tagged_dispatch_fifos
    import dispatch_pkg::*;
#(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int TAGWIDTH  = tag_bits(NUM_FIFOS),
    parameter int REDIRECT  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [TAGWIDTH-1:0]        tag_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       ready,
    output logic [TAGWIDTH-1:0]        acc_tag,
    input  logic [NUM_FIFOS-1:0]       pop,
    output logic [NUM_FIFOS*WIDTH-1:0] flat_data_out,
    output logic [NUM_FIFOS-1:0]       full,
    output logic [NUM_FIFOS-1:0]       empty,
    output logic                       err_overflow,
    output logic                       err_underflow,
    output logic                       err_bad_tag
);

    logic [31:0]          tag_ext;
    logic [31:0]          cand;
    logic                 bad_tag;
    logic                 req_full;
    logic                 found;
    logic [NUM_FIFOS-1:0] wr;
    logic [NUM_ERR-1:0]   err_q;

    assign tag_ext = 32'(tag_in);

    // Selection looks only at registered full, so a pop in the same
    // cycle never frees space for the push.
    always_comb begin
        bad_tag  = (tag_ext >= 32'(NUM_FIFOS));
        req_full = 1'b0;
        cand     = '0;
        found    = 1'b0;
        acc_tag  = tag_in;
        ready    = 1'b0;
        for (int j = 0; j < NUM_FIFOS; j++) begin
            if (tag_ext == 32'(j)) req_full = full[j];
        end
        if (REDIRECT != 0) begin
            // Offset 0 is the requested channel itself.
            for (int k = 0; k < NUM_FIFOS; k++) begin
                cand = tag_ext + 32'(k);
                if (cand >= 32'(NUM_FIFOS)) begin
                    cand = cand - 32'(NUM_FIFOS);
                end
                for (int j = 0; j < NUM_FIFOS; j++) begin
                    if (!found && cand == 32'(j) && !full[j]) begin
                        found   = 1'b1;
                        acc_tag = TAGWIDTH'(j);
                    end
                end
            end
        end
        if (bad_tag) begin
            ready = 1'b0;
        end else if (REDIRECT != 0) begin
            ready = found;
        end else begin
            ready = !req_full;
        end
    end

    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_ch
        assign wr[i] = push & ready & (acc_tag == TAGWIDTH'(i));

        dispatch_channel_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (wr[i]),
            .pop      (pop[i]),
            .data_in  (data_in),
            .data_out (flat_data_out[i*WIDTH +: WIDTH]),
            .full     (full[i]),
            .empty    (empty[i])
        );
    end

    // A bad tag is reported on its own flag, not as an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            if (push && !ready && !bad_tag) err_q[ERR_OVERFLOW] <= 1'b1;
            if (push && bad_tag)            err_q[ERR_BAD_TAG]  <= 1'b1;
            if (|(pop & empty))             err_q[ERR_UNDERFLOW] <= 1'b1;
        end
    end

    assign err_overflow  = err_q[ERR_OVERFLOW];
    assign err_underflow = err_q[ERR_UNDERFLOW];
    assign err_bad_tag   = err_q[ERR_BAD_TAG];

endmodule
